// File: rtl/draw_pkg.sv
// Shared constants for the VGA overlay stages: highlight modes and screen geometry.
package draw_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_SOLID  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BORDER = 2'd3
    } hl_mode_e;

    localparam int H_RES = 1024;
    localparam int V_RES = 768;

endpackage

// File: rtl/frame_blinker.sv
// Frame-boundary detector and blink timer; frame_start marks the cycle the active selection loads.
module frame_blinker #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic vsync_in,
    input  logic restart,
    output logic frame_start,
    output logic blink_on
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic             vsync_q;
    logic [CNT_W-1:0] frame_cnt;

    assign frame_start = vsync_in & ~vsync_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            vsync_q <= vsync_in;
            if (frame_start) begin
                // A new mode restarts the blink visible rather than mid-phase
                if (restart) begin
                    frame_cnt <= '0;
                    blink_on  <= 1'b1;
                end else if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/draw_cell_highlight.sv
// Two-stage overlay that paints one selectable cell of a ROWS x COLS grid (solid, blinking or border).
module draw_cell_highlight
    import draw_pkg::*;
#(
    parameter int ROWS         = 3,
    parameter int COLS         = 3,
    parameter int CELL_W       = 341,
    parameter int CELL_H       = 256,
    parameter int X0           = 0,
    parameter int Y0           = 0,
    parameter int BORDER       = 8,
    parameter int BLINK_FRAMES = 30,
    localparam int IDX_W       = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [10:0]      hcount_in,
    input  logic [10:0]      vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [11:0]      rgb_in,
    input  logic             start_en,
    input  logic             choice_en,
    input  logic [IDX_W-1:0] sel_idx,
    input  logic [1:0]       sel_mode,
    input  logic [11:0]      sel_color,
    output logic [10:0]      hcount_out,
    output logic [10:0]      vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [11:0]      rgb_out
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    function automatic logic [11:0] x_bound(input int c);
        return 12'(X0 + c * CELL_W);
    endfunction

    function automatic logic [11:0] y_bound(input int r);
        return 12'(Y0 + r * CELL_H);
    endfunction

    hl_mode_e         active_mode;
    logic [IDX_W-1:0] active_idx;
    logic [11:0]      active_color;
    hl_mode_e         load_mode;
    logic             frame_start;
    logic             blink_on;
    logic             restart;

    assign load_mode = (int'(sel_idx) >= ROWS * COLS) ? MODE_OFF : hl_mode_e'(sel_mode);
    assign restart   = frame_start && (load_mode != active_mode);

    frame_blinker #(.BLINK_FRAMES(BLINK_FRAMES)) u_blinker (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .vsync_in    (vsync_in),
        .restart     (restart),
        .frame_start (frame_start),
        .blink_on    (blink_on)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            active_mode  <= MODE_OFF;
            active_idx   <= '0;
            active_color <= '0;
        end else if (frame_start) begin
            active_mode  <= load_mode;
            active_idx   <= sel_idx;
            active_color <= sel_color;
        end
    end

    logic [CW-1:0]    col_c;
    logic [RW-1:0]    row_c;
    logic [10:0]      off_x, off_y;
    logic             in_x, in_y, edge_x, edge_y;
    logic [IDX_W-1:0] cell_c;

    // Parallel compares against constant cell boundaries; the last boundary passed wins,
    // so a pixel on a shared boundary belongs to the right/lower cell.
    always_comb begin
        col_c = '0;
        off_x = '0;
        for (int c = 0; c < COLS; c++) begin
            if ({1'b0, hcount_in} >= x_bound(c)) begin
                col_c = CW'(c);
                off_x = hcount_in - 11'(x_bound(c));
            end
        end
        row_c = '0;
        off_y = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ({1'b0, vcount_in} >= y_bound(r)) begin
                row_c = RW'(r);
                off_y = vcount_in - 11'(y_bound(r));
            end
        end
        in_x   = ({1'b0, hcount_in} >= x_bound(0)) && ({1'b0, hcount_in} < x_bound(COLS));
        in_y   = ({1'b0, vcount_in} >= y_bound(0)) && ({1'b0, vcount_in} < y_bound(ROWS));
        edge_x = (off_x < 11'(BORDER)) || (off_x >= 11'(CELL_W - BORDER));
        edge_y = (off_y < 11'(BORDER)) || (off_y >= 11'(CELL_H - BORDER));
        cell_c = IDX_W'(int'(row_c) * COLS + int'(col_c));
    end

    logic [10:0]      hcount_p1, vcount_p1;
    logic             hsync_p1, vsync_p1, hblnk_p1, vblnk_p1;
    logic [11:0]      rgb_p1;
    logic [IDX_W-1:0] cell_p1;
    logic             in_grid_p1, edge_p1, ovl_en_p1;

    // Stage 1: cell decode and timing delay
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_p1  <= '0;
            vcount_p1  <= '0;
            hsync_p1   <= 1'b0;
            vsync_p1   <= 1'b0;
            hblnk_p1   <= 1'b0;
            vblnk_p1   <= 1'b0;
            rgb_p1     <= '0;
            cell_p1    <= '0;
            in_grid_p1 <= 1'b0;
            edge_p1    <= 1'b0;
            ovl_en_p1  <= 1'b0;
        end else begin
            hcount_p1  <= hcount_in;
            vcount_p1  <= vcount_in;
            hsync_p1   <= hsync_in;
            vsync_p1   <= vsync_in;
            hblnk_p1   <= hblnk_in;
            vblnk_p1   <= vblnk_in;
            rgb_p1     <= rgb_in;
            cell_p1    <= cell_c;
            in_grid_p1 <= in_x & in_y;
            edge_p1    <= edge_x | edge_y;
            ovl_en_p1  <= start_en & ~choice_en;
        end
    end

    logic hit;
    logic paint;

    always_comb begin
        hit = in_grid_p1 & ovl_en_p1 & (cell_p1 == active_idx) & ~hblnk_p1 & ~vblnk_p1;
        case (active_mode)
            MODE_SOLID:  paint = hit;
            MODE_BLINK:  paint = hit & blink_on;
            MODE_BORDER: paint = hit & edge_p1;
            default:     paint = 1'b0;
        endcase
    end

    // Stage 2: colour select and output registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_p1;
            vcount_out <= vcount_p1;
            hsync_out  <= hsync_p1;
            vsync_out  <= vsync_p1;
            hblnk_out  <= hblnk_p1;
            vblnk_out  <= vblnk_p1;
            rgb_out    <= paint ? active_color : rgb_p1;
        end
    end

endmodule

// File: tb/tb_draw_cell_highlight.sv
// Directed bench for draw_cell_highlight: 3x3 grid of 341x256 cells, BORDER=8, BLINK_FRAMES=2.
module tb_draw_cell_highlight;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic        start_en, choice_en;
    logic [3:0]  sel_idx;
    logic [1:0]  sel_mode;
    logic [11:0] sel_color;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    draw_cell_highlight #(.BLINK_FRAMES(2)) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .start_en   (start_en),
        .choice_en  (choice_en),
        .sel_idx    (sel_idx),
        .sel_mode   (sel_mode),
        .sel_color  (sel_color),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    // Apply one pixel, hold it, and return rgb_out two edges later
    task automatic px(input logic [10:0] x, input logic [10:0] y, input logic [11:0] c,
                      output logic [11:0] o);
        @(negedge pclk);
        hcount_in = x;
        vcount_in = y;
        rgb_in    = c;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        o = rgb_out;
    endtask

    task automatic frame();
        @(negedge pclk);
        vsync_in = 1'b1;
        @(negedge pclk);
        vsync_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] o;
        #1;
        n_cmp++;
        if (rgb_out !== 12'h000 || hcount_out !== 11'd0 || hsync_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: rgb=%h hcount=%0d hsync=%b, want 000/0/0", rgb_out, hcount_out, hsync_out);
        end
        @(negedge pclk);
        rst_n = 1'b1;
        px(11'd500, 11'd300, 12'hABC, o);
        n_cmp++;
        if (o !== 12'hABC) begin
            n_bad++;
            $display("FAIL reset_mode_off: rgb=%h want ABC", o);
        end
    endtask

    task automatic test_solid();
        logic [11:0] o;
        frame();
        px(11'd500, 11'd300, 12'h123, o);
        n_cmp++; if (o !== 12'hF00) begin n_bad++; $display("FAIL solid_500_300: rgb=%h want F00", o); end
        px(11'd200, 11'd300, 12'h456, o);
        n_cmp++; if (o !== 12'h456) begin n_bad++; $display("FAIL solid_200_300: rgb=%h want 456", o); end
        px(11'd341, 11'd256, 12'h111, o);
        n_cmp++; if (o !== 12'hF00) begin n_bad++; $display("FAIL solid_341_256: rgb=%h want F00", o); end
        px(11'd340, 11'd256, 12'h789, o);
        n_cmp++; if (o !== 12'h789) begin n_bad++; $display("FAIL solid_340_256: rgb=%h want 789", o); end
        px(11'd681, 11'd511, 12'h222, o);
        n_cmp++; if (o !== 12'hF00) begin n_bad++; $display("FAIL solid_681_511: rgb=%h want F00", o); end
        px(11'd682, 11'd300, 12'h333, o);
        n_cmp++; if (o !== 12'h333) begin n_bad++; $display("FAIL solid_682_300: rgb=%h want 333", o); end
        frame();
        px(11'd500, 11'd300, 12'h444, o);
        n_cmp++; if (o !== 12'hF00) begin n_bad++; $display("FAIL solid_frame2: rgb=%h want F00", o); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] xs [4] = '{11'd500, 11'd10, 11'd400, 11'd20};
        logic [11:0] cs [4] = '{12'h0A1, 12'h0A2, 12'h0A3, 12'h0A4};
        logic        hs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [11:0] ex [4] = '{12'hF00, 12'h0A2, 12'hF00, 12'h0A4};
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (i < 4) begin
                hcount_in = xs[i];
                vcount_in = 11'd300;
                rgb_in    = cs[i];
                hsync_in  = hs[i];
            end
            @(posedge pclk);
            #1;
            if (i >= 1) begin
                n_cmp++;
                if (rgb_out !== ex[i-1] || hcount_out !== xs[i-1] || hsync_out !== hs[i-1]) begin
                    n_bad++;
                    $display("FAIL b2b_%0d: rgb=%h h=%0d hs=%b want %h/%0d/%b",
                             i - 1, rgb_out, hcount_out, hsync_out, ex[i-1], xs[i-1], hs[i-1]);
                end
            end
        end
        hsync_in = 1'b0;
    endtask

    task automatic test_blink();
        logic [11:0] o;
        logic [11:0] want;
        sel_mode  = 2'd2;
        sel_idx   = 4'd0;
        sel_color = 12'h0F0;
        frame();
        for (int f = 1; f <= 6; f++) begin
            want = (f == 3 || f == 4) ? 12'h00A : 12'h0F0;
            px(11'd10, 11'd10, 12'h00A, o);
            n_cmp++;
            if (o !== want) begin n_bad++; $display("FAIL blink_frame%0d: rgb=%h want %h", f, o, want); end
            frame();
        end
    endtask

    task automatic test_border();
        logic [11:0] o;
        sel_mode  = 2'd3;
        sel_idx   = 4'd8;
        sel_color = 12'h00F;
        frame();
        px(11'd685, 11'd520, 12'h101, o);
        n_cmp++; if (o !== 12'h00F) begin n_bad++; $display("FAIL border_685_520: rgb=%h want 00F", o); end
        px(11'd681, 11'd520, 12'h102, o);
        n_cmp++; if (o !== 12'h102) begin n_bad++; $display("FAIL border_681_520: rgb=%h want 102", o); end
        px(11'd1022, 11'd767, 12'h103, o);
        n_cmp++; if (o !== 12'h00F) begin n_bad++; $display("FAIL border_1022_767: rgb=%h want 00F", o); end
        px(11'd1023, 11'd767, 12'h104, o);
        n_cmp++; if (o !== 12'h104) begin n_bad++; $display("FAIL border_1023_767: rgb=%h want 104", o); end
        px(11'd850, 11'd640, 12'h105, o);
        n_cmp++; if (o !== 12'h105) begin n_bad++; $display("FAIL border_850_640: rgb=%h want 105", o); end
        px(11'd690, 11'd520, 12'h106, o);
        n_cmp++; if (o !== 12'h106) begin n_bad++; $display("FAIL border_690_520: rgb=%h want 106", o); end
        px(11'd850, 11'd519, 12'h107, o);
        n_cmp++; if (o !== 12'h00F) begin n_bad++; $display("FAIL border_850_519: rgb=%h want 00F", o); end
    endtask

    task automatic test_mid_change();
        logic [11:0] o;
        sel_mode  = 2'd1;
        sel_idx   = 4'd0;
        sel_color = 12'hFFF;
        frame();
        px(11'd10, 11'd10, 12'h201, o);
        n_cmp++; if (o !== 12'hFFF) begin n_bad++; $display("FAIL mid_before: rgb=%h want FFF", o); end
        sel_idx = 4'd2;
        px(11'd10, 11'd10, 12'h202, o);
        n_cmp++; if (o !== 12'hFFF) begin n_bad++; $display("FAIL mid_hold_cell0: rgb=%h want FFF", o); end
        px(11'd700, 11'd10, 12'h203, o);
        n_cmp++; if (o !== 12'h203) begin n_bad++; $display("FAIL mid_hold_cell2: rgb=%h want 203", o); end
        frame();
        px(11'd10, 11'd10, 12'h204, o);
        n_cmp++; if (o !== 12'h204) begin n_bad++; $display("FAIL next_cell0: rgb=%h want 204", o); end
        px(11'd700, 11'd10, 12'h205, o);
        n_cmp++; if (o !== 12'hFFF) begin n_bad++; $display("FAIL next_cell2: rgb=%h want FFF", o); end
        // selection changes in the very cycle of the vsync edge
        @(negedge pclk);
        vsync_in = 1'b1;
        sel_idx  = 4'd5;
        @(negedge pclk);
        vsync_in = 1'b0;
        px(11'd700, 11'd300, 12'h206, o);
        n_cmp++; if (o !== 12'hFFF) begin n_bad++; $display("FAIL edge_same_cycle: rgb=%h want FFF", o); end
    endtask

    task automatic test_suppress();
        logic [11:0] o;
        choice_en = 1'b1;
        px(11'd700, 11'd300, 12'h301, o);
        n_cmp++; if (o !== 12'h301) begin n_bad++; $display("FAIL sup_choice: rgb=%h want 301", o); end
        choice_en = 1'b0;
        hblnk_in  = 1'b1;
        px(11'd700, 11'd300, 12'h302, o);
        n_cmp++; if (o !== 12'h302) begin n_bad++; $display("FAIL sup_hblnk: rgb=%h want 302", o); end
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b1;
        px(11'd700, 11'd300, 12'h303, o);
        n_cmp++; if (o !== 12'h303) begin n_bad++; $display("FAIL sup_vblnk: rgb=%h want 303", o); end
        vblnk_in  = 1'b0;
        start_en  = 1'b0;
        px(11'd700, 11'd300, 12'h304, o);
        n_cmp++; if (o !== 12'h304) begin n_bad++; $display("FAIL sup_start: rgb=%h want 304", o); end
        start_en  = 1'b1;
        sel_idx   = 4'd9;
        frame();
        px(11'd10, 11'd10, 12'h305, o);
        n_cmp++; if (o !== 12'h305) begin n_bad++; $display("FAIL sup_idx9_a: rgb=%h want 305", o); end
        px(11'd1022, 11'd767, 12'h306, o);
        n_cmp++; if (o !== 12'h306) begin n_bad++; $display("FAIL sup_idx9_b: rgb=%h want 306", o); end
    endtask

    task automatic test_async_reset();
        logic [11:0] o;
        sel_mode  = 2'd1;
        sel_idx   = 4'd4;
        sel_color = 12'hF00;
        frame();
        @(negedge pclk);
        hcount_in = 11'd500;
        vcount_in = 11'd300;
        rgb_in    = 12'h555;
        hsync_in  = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        n_cmp++;
        if (rgb_out !== 12'hF00 || hcount_out !== 11'd500 || hsync_out !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_before: rgb=%h h=%0d hs=%b want F00/500/1", rgb_out, hcount_out, hsync_out);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rgb_out !== 12'h000 || hcount_out !== 11'd0 || vcount_out !== 11'd0 || hsync_out !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_async: rgb=%h h=%0d v=%0d hs=%b want all 0", rgb_out, hcount_out, vcount_out, hsync_out);
        end
        hsync_in = 1'b0;
        @(negedge pclk);
        rst_n = 1'b1;
        px(11'd500, 11'd300, 12'h111, o);
        n_cmp++; if (o !== 12'h111) begin n_bad++; $display("FAIL arst_off: rgb=%h want 111", o); end
        frame();
        px(11'd500, 11'd300, 12'h112, o);
        n_cmp++; if (o !== 12'hF00) begin n_bad++; $display("FAIL arst_reload: rgb=%h want F00", o); end
    endtask

    initial begin
        rst_n     = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        rgb_in    = '0;
        start_en  = 1'b1;
        choice_en = 1'b0;
        sel_idx   = 4'd4;
        sel_mode  = 2'd1;
        sel_color = 12'hF00;
        repeat (3) @(posedge pclk);
        test_reset();
        test_solid();
        test_back_to_back();
        test_blink();
        test_border();
        test_mid_change();
        test_suppress();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
